// File: rtl/q_pkg.sv
// Shared definitions for the Q-learning datapath: widths, scan FSM states, constants.
package q_pkg;

    localparam int Q_W   = 16;
    localparam int N_ACT = 9;
    localparam int ACT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } scan_state_t;

    localparam logic signed [Q_W-1:0] Q_ZERO   = '0;
    localparam logic [ACT_W-1:0]      ACT_ZERO = '0;
    localparam logic [ACT_W-1:0]      LAST_ACT = ACT_W'(N_ACT - 1);

endpackage

// File: rtl/q_cmp_sel.sv
// Combinational signed compare-select with first-valid override.
// The first legal candidate always wins so the accumulator is never seeded with zero.
module q_cmp_sel
    import q_pkg::*;
(
    input  logic signed [Q_W-1:0]   acc,
    input  logic        [ACT_W-1:0] acc_act,
    input  logic signed [Q_W-1:0]   cand,
    input  logic        [ACT_W-1:0] cand_act,
    input  logic                    cand_legal,
    input  logic                    seen,
    output logic signed [Q_W-1:0]   acc_nxt,
    output logic        [ACT_W-1:0] act_nxt,
    output logic                    seen_nxt
);

    logic take;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        take     = cand_legal && (!seen || (cand > acc));
        acc_nxt  = acc;
        act_nxt  = acc_act;
        seen_nxt = seen | cand_legal;
        if (take) begin
            acc_nxt = cand;
            act_nxt = cand_act;
        end
    end

endmodule

// File: rtl/q_max_scan.sv
// Sequential max-search over the nine Q-values of a state, legal actions only.
// Fixed 11-cycle latency from start to done; all nine entries are always read.
module q_max_scan
    import q_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [N_ACT-1:0]        legal_mask,
    output logic                    rd_en,
    output logic [ACT_W-1:0]        rd_addr,
    input  logic signed [Q_W-1:0]   rd_data,
    output logic                    busy,
    output logic                    done,
    output logic signed [Q_W-1:0]   max_q,
    output logic [ACT_W-1:0]        best_act,
    output logic                    none_legal
);

    scan_state_t              state_q, state_d;
    logic [ACT_W-1:0]         cnt_q, cnt_d;
    logic [N_ACT-1:0]         mask_q, mask_d;
    logic                     seen_q, seen_d;
    logic                     vld_p1_q, vld_p1_d;
    logic [ACT_W-1:0]         act_p1_q, act_p1_d;
    logic signed [Q_W-1:0]    acc_q, acc_d;
    logic [ACT_W-1:0]         acc_act_q, acc_act_d;
    logic signed [Q_W-1:0]    max_out_q, max_out_d;
    logic [ACT_W-1:0]         best_out_q, best_out_d;
    logic                     none_out_q, none_out_d;

    logic signed [Q_W-1:0]    cmp_acc;
    logic [ACT_W-1:0]         cmp_act;
    logic                     cmp_seen;
    logic                     cand_legal;

    assign cand_legal = vld_p1_q && mask_q[act_p1_q];

    q_cmp_sel u_cmp_sel (
        .acc        (acc_q),
        .acc_act    (acc_act_q),
        .cand       (rd_data),
        .cand_act   (act_p1_q),
        .cand_legal (cand_legal),
        .seen       (seen_q),
        .acc_nxt    (cmp_acc),
        .act_nxt    (cmp_act),
        .seen_nxt   (cmp_seen)
    );

    // Next-state, read sequencing, accumulator update and result capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        seen_d     = seen_q;
        acc_d      = acc_q;
        acc_act_d  = acc_act_q;
        max_out_d  = max_out_q;
        best_out_d = best_out_q;
        none_out_d = none_out_q;
        // Returning data belongs to the address issued one cycle earlier.
        vld_p1_d   = (state_q == ISSUE);
        act_p1_d   = cnt_q;

        if (vld_p1_q) begin
            acc_d     = cmp_acc;
            acc_act_d = cmp_act;
            seen_d    = cmp_seen;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ISSUE;
                    mask_d    = legal_mask;
                    cnt_d     = ACT_ZERO;
                    seen_d    = 1'b0;
                    acc_d     = Q_ZERO;
                    acc_act_d = ACT_ZERO;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ACT) begin
                    cnt_d   = ACT_ZERO;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Last read lands this cycle; publish results on entry to DONE.
                state_d    = DONE;
                max_out_d  = cmp_seen ? cmp_acc : Q_ZERO;
                best_out_d = cmp_seen ? cmp_act : ACT_ZERO;
                none_out_d = !cmp_seen;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state and visible results; reset aborts any scan in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= ACT_ZERO;
            mask_q     <= '0;
            seen_q     <= 1'b0;
            vld_p1_q   <= 1'b0;
            act_p1_q   <= ACT_ZERO;
            max_out_q  <= Q_ZERO;
            best_out_q <= ACT_ZERO;
            none_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            seen_q     <= seen_d;
            vld_p1_q   <= vld_p1_d;
            act_p1_q   <= act_p1_d;
            max_out_q  <= max_out_d;
            best_out_q <= best_out_d;
            none_out_q <= none_out_d;
        end
    end

    // Running maximum; cleared on every accepted start, so no reset needed.
    always_ff @(posedge clk) begin
        acc_q     <= acc_d;
        acc_act_q <= acc_act_d;
    end

    assign rd_en      = (state_q == ISSUE);
    assign rd_addr    = cnt_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign max_q      = max_out_q;
    assign best_act   = best_out_q;
    assign none_legal = none_out_q;

endmodule

// File: tb/tb_q_max_scan.sv
// Directed testbench for q_max_scan with a behavioural synchronous Q-table RAM.
module tb_q_max_scan;

    logic        clk;
    logic        rst;
    logic        start;
    logic [8:0]  legal_mask;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
    logic [15:0] max_q;
    logic [3:0]  best_act;
    logic        none_legal;

    logic [15:0] ram [0:8];

    int n_total;
    int n_pass;

    q_max_scan dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .legal_mask (legal_mask),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .max_q      (max_q),
        .best_act   (best_act),
        .none_legal (none_legal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM: data valid the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en && rd_addr < 4'd9) rd_data <= ram[rd_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // Start a scan in cycle 0 and check cycles 1..12 against the fixed timeline.
    // restart_c: cycle in which start is pulsed again (0 = never).
    // chg_c: cycle in which legal_mask is inverted (0 = never).
    task automatic run_scan(input string tag, input logic [8:0] mask,
                            input logic [15:0] emax, input logic [3:0] eact,
                            input logic enone, input int restart_c, input int chg_c);
        @(posedge clk);
        #1;
        start      = 1'b1;
        legal_mask = mask;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            start = (c == restart_c);
            if (c == chg_c) legal_mask = legal_mask ^ 9'h1FF;
            @(negedge clk);
            check({tag, "_done"}, 32'(done), 32'(c == 11));
            check({tag, "_busy"}, 32'(busy), 32'(c <= 11));
            check({tag, "_rd_en"}, 32'(rd_en), 32'(c >= 1 && c <= 9));
            if (c >= 1 && c <= 9)
                check({tag, "_rd_addr"}, 32'(rd_addr), 32'(c - 1));
            if (c >= 11) begin
                check({tag, "_max_q"}, 32'(max_q), 32'(emax));
                check({tag, "_best_act"}, 32'(best_act), 32'(eact));
                check({tag, "_none"}, 32'(none_legal), 32'(enone));
            end
        end
    endtask

    initial begin
        n_total    = 0;
        n_pass     = 0;
        rst        = 1'b1;
        start      = 1'b0;
        legal_mask = 9'h000;
        for (int i = 0; i < 9; i++) ram[i] = 16'(i * 10);

        // Reset state
        @(negedge clk);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_max_q", 32'(max_q), 32'd0);
        check("rst_best_act", 32'(best_act), 32'd0);
        check("rst_none", 32'(none_legal), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // All legal, ascending values
        run_scan("asc", 9'h1FF, 16'd80, 4'd8, 1'b0, 0, 0);

        // All equal negative: tie goes to index 0, no zero seeding
        for (int i = 0; i < 9; i++) ram[i] = 16'hFFFB;
        run_scan("neg_tie", 9'h1FF, 16'hFFFB, 4'd0, 1'b0, 0, 0);

        // Sparse mask; illegal large entry ignored
        for (int i = 0; i < 9; i++) ram[i] = 16'd0;
        ram[0] = 16'd500;
        ram[2] = 16'hFFFD;
        ram[5] = 16'd7;
        run_scan("sparse", 9'b000100100, 16'd7, 4'd5, 1'b0, 0, 0);

        // Terminal board
        run_scan("none", 9'h000, 16'd0, 4'd0, 1'b1, 0, 0);

        // Restart while busy and mask change after capture are ignored
        run_scan("ignore", 9'b000100100, 16'd7, 4'd5, 1'b0, 4, 5);

        // Reset mid-scan at cycle 6
        @(posedge clk);
        #1;
        start      = 1'b1;
        legal_mask = 9'h1FF;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (c == 6) rst = 1'b1;
            if (c == 8) rst = 1'b0;
            @(negedge clk);
            if (c == 6) begin
                check("mrst_rd_en", 32'(rd_en), 32'd0);
                check("mrst_rd_addr", 32'(rd_addr), 32'd0);
                check("mrst_busy", 32'(busy), 32'd0);
                check("mrst_max_q", 32'(max_q), 32'd0);
                check("mrst_best_act", 32'(best_act), 32'd0);
                check("mrst_none", 32'(none_legal), 32'd0);
            end
            if (c >= 6) check("mrst_no_done", 32'(done), 32'd0);
        end

        // Fresh scan after reset release
        for (int i = 0; i < 9; i++) ram[i] = 16'(i * 10);
        run_scan("post_rst", 9'h1FF, 16'd80, 4'd8, 1'b0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
